alu_writeback: RTL
==================

Name: alu_writeback

Overview:
- Stage directly downstream of the registered ALU.
- Tracks each issued ALU operation through the ALU's one-cycle latency and drives the register-file write port with the ALU result.
- Owns the architectural status register (C, Z, N, V) and supplies the forwarded carry_in back to the ALU.
- Evaluates branch condition codes and reports operand-forwarding hits to the issue stage.

Parameters:
- REG_INDEX_WIDTH, 4: width of register-file index (16 registers).

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
issue_valid  input  1  ALU operation presented to ALU this cycle
issue_dest  input  REG_INDEX_WIDTH  destination register of issued op
issue_write_en  input  1  issued op writes its result (0 for COMP/BIT/TEST)
issue_flags_en  input  1  issued op updates status register
alu_result  input  32  ALU result, valid the cycle after issue
alu_carry, alu_zero, alu_neg, alu_over  input  1 each  ALU flags, valid the cycle after issue
carry_in  output  1  carry to ALU, forwarded
status_load  input  1  software write of status register
status_load_data  input  4  {C,Z,N,V} for status_load
status  output  4  architectural {C,Z,N,V}
cond_code  input  4  condition to evaluate
cond_true  output  1  condition result against effective flags
src_a, src_b  input  REG_INDEX_WIDTH  source indices of op being issued
fwd_hit_a, fwd_hit_b  output  1 each  source matches in-flight write
fwd_data  output  32  forwarded value (= alu_result)
reg_write  output  1  register-file write strobe
reg_write_index  output  REG_INDEX_WIDTH  write index
reg_write_data  output  32  write data

Behaviour:
- Reset value of every register and output: 0, including status, pending stage, reg_write and carry_in. Reset mid-operation discards the in-flight op: no write and no flag update occur.
- Pending stage, registered:
  - On each clock, pend_valid <= issue_valid.
  - pend_dest, pend_write_en and pend_flags_en are captured from the issue_* inputs when issue_valid=1.
- Write port, combinational from pending stage:
  - reg_write = pend_valid & pend_write_en.
  - reg_write_index = pend_dest.
  - reg_write_data = alu_result.
  - Latency: issue in cycle k gives the write in cycle k+1. Back-to-back issue every cycle is supported.
- Effective flags:
  - flags_fwd = pend_valid & pend_flags_en.
  - eff = flags_fwd ? {alu_carry, alu_zero, alu_neg, alu_over} : status.
  - carry_in = eff.C, so ADDC/SUBC issued immediately after a flag-setting op sees the new carry.
- Status update at the clock edge, in priority order:
  1. status_load, which wins over a simultaneous in-flight update because it is later in program order.
  2. flags_fwd, which loads the ALU flags.
  3. Otherwise status holds.
- Condition codes: C is borrow on subtract, so unsigned tests use inverted C.
  0 AL=1; 1 EQ=Z; 2 NE=!Z; 3 CS=C; 4 CC=!C; 5 MI=N; 6 PL=!N; 7 VS=V; 8 VC=!V; 9 HI=!C&!Z; 10 LS=C|Z; 11 GE=N==V; 12 LT=N!=V; 13 GT=!Z&(N==V); 14 LE=Z|(N!=V); 15 NV=0.
  cond_true is evaluated combinationally against eff.
- Forwarding:
  - fwd_hit_a = reg_write & (pend_dest == src_a); same for b.
  - fwd_data = alu_result.
  - No stall is required: the ALU result is always available in the following cycle.
- issue_valid=0 with pending ops: the stage drains in one cycle.
- The ALU's flags for ops without issue_flags_en are ignored.

Decomposition:
- Shared package alu_writeback.vh:
  - COND_* constants 0..15.
  - Status bit positions STATUS_C=3, STATUS_Z=2, STATUS_N=1, STATUS_V=0.
- One natural sub-module: cond_eval, a combinational function of cond_code and the 4-bit flags.

Test Plan:
- Issue ADD into r3 (flags_en=1) in cycle 0, alu_result=0x00000005, flags 0000 in cycle 1 -> reg_write=1, index=3, data=0x00000005 in cycle 1; status=0000 in cycle 2.
- SUB 1-2: cycle 1 alu_result=0xFFFFFFFF, C=1, N=1; ADDC issued in cycle 1 -> carry_in=1 in cycle 1; cond LT (12) true in cycle 1, before status updates.
- COMP (write_en=0, flags_en=1) yielding Z=1 -> reg_write=0, status.Z=1 next cycle, cond EQ true, NE false.
- Issue to r7 in cycle 0; src_a=7, src_b=2 in cycle 1 -> fwd_hit_a=1, fwd_hit_b=0, fwd_data=alu_result; same with write_en=0 -> both hits 0.
- status_load=1 with data 1010 in the same cycle as an in-flight flag update of 0101 -> status=1010.
- Reset asserted in the cycle after issue -> reg_write=0, status=0000, pend_valid=0; all 16 cond codes checked against flags 0000, where AL, NE, CC, PL, VC, HI, GE, GT are true and the rest are false.

Source files
------------

// File: rtl/alu_writeback_pkg.sv
// alu_writeback_pkg
// Shared definitions for the ALU writeback stage: the branch condition-code
// encodings and the bit positions of the {C,Z,N,V} status register.
// No ports; imported by alu_writeback and alu_writeback_cond_eval.
package alu_writeback_pkg;

    // Condition codes presented on cond_code
    localparam logic [3:0] COND_AL = 4'd0;
    localparam logic [3:0] COND_EQ = 4'd1;
    localparam logic [3:0] COND_NE = 4'd2;
    localparam logic [3:0] COND_CS = 4'd3;
    localparam logic [3:0] COND_CC = 4'd4;
    localparam logic [3:0] COND_MI = 4'd5;
    localparam logic [3:0] COND_PL = 4'd6;
    localparam logic [3:0] COND_VS = 4'd7;
    localparam logic [3:0] COND_VC = 4'd8;
    localparam logic [3:0] COND_HI = 4'd9;
    localparam logic [3:0] COND_LS = 4'd10;
    localparam logic [3:0] COND_GE = 4'd11;
    localparam logic [3:0] COND_LT = 4'd12;
    localparam logic [3:0] COND_GT = 4'd13;
    localparam logic [3:0] COND_LE = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    // Bit positions inside the 4-bit status word {C,Z,N,V}
    localparam int STATUS_C = 3;
    localparam int STATUS_Z = 2;
    localparam int STATUS_N = 1;
    localparam int STATUS_V = 0;

endpackage

// File: rtl/alu_writeback_cond_eval.sv
// alu_writeback_cond_eval
// Purely combinational branch-condition evaluator.
// Ports:
//   cond_code  in  4  condition to test
//   flags      in  4  {C,Z,N,V} to test against
//   cond_true  out 1  condition holds
// C is a borrow on subtract, so the unsigned tests (HI/LS) use it inverted
// relative to the usual carry-based definitions.
module alu_writeback_cond_eval
    import alu_writeback_pkg::*;
(
    input  logic [3:0] cond_code,
    input  logic [3:0] flags,
    output logic       cond_true
);

    logic c, z, n, v;

    assign c = flags[STATUS_C];
    assign z = flags[STATUS_Z];
    assign n = flags[STATUS_N];
    assign v = flags[STATUS_V];

    always_comb begin
        cond_true = 1'b0;
        case (cond_code)
            COND_AL: cond_true = 1'b1;
            COND_EQ: cond_true = z;
            COND_NE: cond_true = ~z;
            COND_CS: cond_true = c;
            COND_CC: cond_true = ~c;
            COND_MI: cond_true = n;
            COND_PL: cond_true = ~n;
            COND_VS: cond_true = v;
            COND_VC: cond_true = ~v;
            COND_HI: cond_true = ~c & ~z;
            COND_LS: cond_true = c | z;
            COND_GE: cond_true = (n == v);
            COND_LT: cond_true = (n != v);
            COND_GT: cond_true = ~z & (n == v);
            COND_LE: cond_true = z | (n != v);
            COND_NV: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback
// Stage directly after the registered ALU. Holds one pending op for the
// ALU's single cycle of latency, drives the register-file write port with
// the ALU result, owns the {C,Z,N,V} status register, forwards carry back
// to the ALU, evaluates branch conditions and reports forwarding hits.
// Ports:
//   clock, reset                  clock, synchronous active-high reset
//   issue_valid/dest/write_en/flags_en   op handed to the ALU this cycle
//   alu_result, alu_carry/zero/neg/over  ALU outputs for the pending op
//   carry_in                      carry to the ALU (forwarded)
//   status_load, status_load_data software write of status
//   status                        architectural {C,Z,N,V}
//   cond_code, cond_true          condition evaluation on effective flags
//   src_a, src_b, fwd_hit_a/b     forwarding match for the op being issued
//   fwd_data                      forwarded value
//   reg_write/_index/_data        register-file write port
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int REG_INDEX_WIDTH = 4
)
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       issue_valid,
    input  logic [REG_INDEX_WIDTH-1:0] issue_dest,
    input  logic                       issue_write_en,
    input  logic                       issue_flags_en,
    input  logic [31:0]                alu_result,
    input  logic                       alu_carry,
    input  logic                       alu_zero,
    input  logic                       alu_neg,
    input  logic                       alu_over,
    output logic                       carry_in,
    input  logic                       status_load,
    input  logic [3:0]                 status_load_data,
    output logic [3:0]                 status,
    input  logic [3:0]                 cond_code,
    output logic                       cond_true,
    input  logic [REG_INDEX_WIDTH-1:0] src_a,
    input  logic [REG_INDEX_WIDTH-1:0] src_b,
    output logic                       fwd_hit_a,
    output logic                       fwd_hit_b,
    output logic [31:0]                fwd_data,
    output logic                       reg_write,
    output logic [REG_INDEX_WIDTH-1:0] reg_write_index,
    output logic [31:0]                reg_write_data
);

    logic                       pend_valid_q, pend_valid_d;
    logic [REG_INDEX_WIDTH-1:0] pend_dest_q, pend_dest_d;
    logic                       pend_write_en_q, pend_write_en_d;
    logic                       pend_flags_en_q, pend_flags_en_d;
    logic [3:0]                 status_q, status_d;

    logic       pend_live;
    logic       flags_fwd;
    logic [3:0] alu_flags;
    logic [3:0] eff_flags;

    // While reset is held the pending op is treated as already discarded,
    // so it can neither write the register file nor be seen as flags.
    assign pend_live = pend_valid_q & ~reset;
    assign flags_fwd = pend_live & pend_flags_en_q;
    assign alu_flags = {alu_carry, alu_zero, alu_neg, alu_over};
    assign eff_flags = flags_fwd ? alu_flags : status_q;

    assign carry_in = eff_flags[STATUS_C] & ~reset;
    assign status   = status_q;

    assign reg_write       = pend_live & pend_write_en_q;
    assign reg_write_index = pend_dest_q;
    assign reg_write_data  = alu_result;

    assign fwd_hit_a = reg_write & (pend_dest_q == src_a);
    assign fwd_hit_b = reg_write & (pend_dest_q == src_b);
    assign fwd_data  = alu_result;

    alu_writeback_cond_eval u_cond_eval (
        .cond_code (cond_code),
        .flags     (eff_flags),
        .cond_true (cond_true)
    );

    always_comb begin
        pend_valid_d    = issue_valid;
        pend_dest_d     = pend_dest_q;
        pend_write_en_d = pend_write_en_q;
        pend_flags_en_d = pend_flags_en_q;
        if (issue_valid) begin
            pend_dest_d     = issue_dest;
            pend_write_en_d = issue_write_en;
            pend_flags_en_d = issue_flags_en;
        end

        // A software load is younger in program order than the op in
        // flight, so it overrides that op's flag update.
        status_d = status_q;
        if (status_load) begin
            status_d = status_load_data;
        end else if (flags_fwd) begin
            status_d = alu_flags;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_valid_q    <= 1'b0;
            pend_dest_q     <= '0;
            pend_write_en_q <= 1'b0;
            pend_flags_en_q <= 1'b0;
            status_q        <= 4'b0000;
        end else begin
            pend_valid_q    <= pend_valid_d;
            pend_dest_q     <= pend_dest_d;
            pend_write_en_q <= pend_write_en_d;
            pend_flags_en_q <= pend_flags_en_d;
            status_q        <= status_d;
        end
    end

endmodule
